// File: rtl/kbd_scan_seq.sv
// PS/2 scancode sequencer: parses make/break/E0 prefixes, drives the key lookup and emits key events.
// Optional KBD_SEQ_REPEAT_EN: typematic repeats re-run the lookup and pulse key_valid without counting.
module kbd_scan_seq #(
    parameter int DATA_LEN = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic                sc_valid,
    input  logic [7:0]          sc_data,
    output logic                sc_ready,
    output logic [8:0]          lut_key,
    input  logic [DATA_LEN-1:0] lut_data,
    input  logic                lut_hit,
    output logic                key_valid,
    output logic [7:0]          key_code,
    output logic                key_ext,
    output logic [DATA_LEN-1:0] key_ascii,
    output logic                key_down,
    output logic [CNT_W-1:0]    press_cnt,
    output logic                err
);

    // state  | meaning
    // IDLE   | waiting for a fresh scancode
    // EXT    | E0 prefix seen, next code is extended
    // BRK    | F0 prefix seen, next code is a release
    // LOOKUP | lut_key presented, sample table result this cycle
    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_LOOKUP} state_t;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    state_t     state;
    logic       ext;
    logic [8:0] held;
    logic       accept;
    logic       new_press;

    assign sc_ready  = (state != S_LOOKUP);
    assign accept    = sc_valid && sc_ready;
    assign new_press = !key_down || (lut_key != held);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= S_IDLE;
            ext       <= 1'b0;
            held      <= '0;
            lut_key   <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_ascii <= '0;
            key_down  <= 1'b0;
            press_cnt <= '0;
            err       <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                S_IDLE, S_EXT: begin
                    if (accept) begin
                        if (sc_data == SC_EXT) begin
                            ext   <= 1'b1;
                            state <= S_EXT;
                        end else if (sc_data == SC_BRK) begin
                            state <= S_BRK;
                        end else begin
                            lut_key <= {(state == S_EXT) && ext, sc_data};
                            state   <= S_LOOKUP;
                        end
                    end
                end
                S_BRK: begin
                    if (accept) begin
                        if (sc_data == SC_EXT || sc_data == SC_BRK) begin
                            err <= 1'b1;
                        end else if (key_down && ({ext, sc_data} == held)) begin
                            // only the currently held key can be released; stale releases are ignored
                            key_down <= 1'b0;
                        end
                        ext   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_LOOKUP: begin
                    if (new_press) begin
                        key_valid <= 1'b1;
                        key_code  <= lut_key[7:0];
                        key_ext   <= lut_key[8];
                        key_ascii <= lut_hit ? lut_data : '0;
                        key_down  <= 1'b1;
                        held      <= lut_key;
                        press_cnt <= press_cnt + 1'b1;
                    end
`ifdef KBD_SEQ_REPEAT_EN
                    else begin
                        key_valid <= 1'b1;
                        key_code  <= lut_key[7:0];
                        key_ext   <= lut_key[8];
                        key_ascii <= lut_hit ? lut_data : '0;
                    end
`endif
                    ext   <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    ext   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_scan_seq.sv
// Self-checking bench for kbd_scan_seq: protocol-level reference model plus directed and random scancode streams.
module tb_kbd_scan_seq;
    localparam int DATA_LEN = 8;
    localparam int CNT_W    = 8;

    logic                clk = 1'b0;
    logic                clrn = 1'b0;
    logic                sc_valid = 1'b0;
    logic [7:0]          sc_data = 8'h00;
    logic                sc_ready;
    logic [8:0]          lut_key;
    logic [DATA_LEN-1:0] lut_data;
    logic                lut_hit;
    logic                key_valid;
    logic [7:0]          key_code;
    logic                key_ext;
    logic [DATA_LEN-1:0] key_ascii;
    logic                key_down;
    logic [CNT_W-1:0]    press_cnt;
    logic                err;

    kbd_scan_seq #(.DATA_LEN(DATA_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .clrn(clrn), .sc_valid(sc_valid), .sc_data(sc_data), .sc_ready(sc_ready),
        .lut_key(lut_key), .lut_data(lut_data), .lut_hit(lut_hit), .key_valid(key_valid),
        .key_code(key_code), .key_ext(key_ext), .key_ascii(key_ascii), .key_down(key_down),
        .press_cnt(press_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // Lookup table stand-in: codes 0x90-0x9F miss, 1C maps to 'a'
    function automatic logic lut_hit_f(input logic [8:0] k);
        return k[7:4] != 4'h9;
    endfunction
    function automatic logic [7:0] lut_data_f(input logic [8:0] k);
        if (k == 9'h01C) return 8'h61;
        return k[7:0] ^ {k[8], 7'h25};
    endfunction
    function automatic logic [7:0] exp_ascii(input logic [8:0] k);
        return lut_hit_f(k) ? lut_data_f(k) : 8'h00;
    endfunction

    always_comb begin
        lut_hit  = lut_hit_f(lut_key);
        lut_data = lut_data_f(lut_key);
    end

    int n_checks = 0;
    int n_fail   = 0;
    int kv_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks prefixes seen, a pending lookup and the held key as protocol facts
    logic             m_pre_ext, m_pre_brk, m_busy;
    logic [8:0]       m_pend, m_key, m_held;
    logic             m_kv, m_kext, m_down, m_err;
    logic [7:0]       m_code, m_ascii;
    logic [CNT_W-1:0] m_cnt;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_pre_ext = 0; m_pre_brk = 0; m_busy = 0;
            m_pend = 0; m_key = 0; m_held = 0;
            m_kv = 0; m_kext = 0; m_down = 0; m_err = 0;
            m_code = 0; m_ascii = 0; m_cnt = 0;
        end else begin
            m_kv = 0;
            if (m_busy) begin
                m_busy = 0;
                if (!m_down || m_pend != m_held) begin
                    m_kv = 1; m_code = m_pend[7:0]; m_kext = m_pend[8];
                    m_ascii = exp_ascii(m_pend); m_down = 1; m_held = m_pend;
                    m_cnt = m_cnt + 1'b1;
                end
`ifdef KBD_SEQ_REPEAT_EN
                else begin
                    m_kv = 1; m_code = m_pend[7:0]; m_kext = m_pend[8];
                    m_ascii = exp_ascii(m_pend);
                end
`endif
            end else if (sc_valid) begin
                if (m_pre_brk) begin
                    if (sc_data == 8'hE0 || sc_data == 8'hF0) m_err = 1;
                    else if (m_down && {m_pre_ext, sc_data} == m_held) m_down = 0;
                    m_pre_brk = 0; m_pre_ext = 0;
                end else if (sc_data == 8'hE0) begin
                    m_pre_ext = 1;
                end else if (sc_data == 8'hF0) begin
                    m_pre_brk = 1;
                end else begin
                    m_busy = 1; m_pend = {m_pre_ext, sc_data}; m_key = m_pend; m_pre_ext = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid) kv_seen++;
        check("sc_ready",  32'(sc_ready),  32'(!m_busy));
        check("lut_key",   32'(lut_key),   32'(m_key));
        check("key_valid", 32'(key_valid), 32'(m_kv));
        check("key_code",  32'(key_code),  32'(m_code));
        check("key_ext",   32'(key_ext),   32'(m_kext));
        check("key_ascii", 32'(key_ascii), 32'(m_ascii));
        check("key_down",  32'(key_down),  32'(m_down));
        check("press_cnt", 32'(press_cnt), 32'(m_cnt));
        check("err",       32'(err),       32'(m_err));
    end

    task automatic idle(input int n);
        sc_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; holds the byte until an edge where sc_ready was high
    task automatic send(input logic [7:0] b, output int waits);
        logic ok, r;
        ok = 0; waits = 0;
        sc_valid = 1'b1; sc_data = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            r = sc_ready;
            @(posedge clk); #1;
            if (r) ok = 1; else waits++;
        end
        sc_valid = 1'b0;
        check("send_accept", 32'(ok), 32'h1);
    endtask

    task automatic tx(input logic [7:0] b);
        int w;
        send(b, w);
    endtask

    task automatic do_reset();
        sc_valid = 1'b0;
        clrn = 1'b0;
        @(posedge clk); #1;
        clrn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int kv0, w;
        logic [7:0] pool [6];
        logic [7:0] c;
        pool = '{8'hE0, 8'hF0, 8'h1C, 8'h75, 8'h99, 8'h2A};

        do_reset();
        check("rst_press_cnt", 32'(press_cnt), 32'h0);
        check("rst_key_down", 32'(key_down), 32'h0);

        // single press and release
        tx(8'h1C);
        check("t1_lut_key", 32'(lut_key), 32'h01C);
        check("t1_no_early_valid", 32'(key_valid), 32'h0);
        idle(1);
        check("t1_valid", 32'(key_valid), 32'h1);
        check("t1_ascii", 32'(key_ascii), 32'h61);
        check("t1_code", 32'(key_code), 32'h1C);
        check("t1_cnt", 32'(press_cnt), 32'h1);
        idle(1);
        check("t1_pulse_end", 32'(key_valid), 32'h0);
        check("t1_down", 32'(key_down), 32'h1);
        tx(8'hF0); tx(8'h1C); idle(1);
        check("t1_released", 32'(key_down), 32'h0);
        check("t1_err", 32'(err), 32'h0);

        // typematic repeat
        do_reset();
        kv0 = kv_seen;
        tx(8'h1C); tx(8'h1C); tx(8'h1C); tx(8'hF0); tx(8'h1C); idle(2);
`ifdef KBD_SEQ_REPEAT_EN
        check("t2_pulses", 32'(kv_seen - kv0), 32'd3);
`else
        check("t2_pulses", 32'(kv_seen - kv0), 32'd1);
`endif
        check("t2_cnt", 32'(press_cnt), 32'h1);

        // extended key
        do_reset();
        tx(8'hE0); tx(8'h75);
        check("t3_lut_key", 32'(lut_key), 32'h175);
        idle(1);
        check("t3_ext", 32'(key_ext), 32'h1);
        check("t3_cnt", 32'(press_cnt), 32'h1);
        tx(8'hE0); tx(8'hF0); tx(8'h75); idle(1);
        check("t3_released", 32'(key_down), 32'h0);

        // lookup miss, then backpressure
        do_reset();
        tx(8'h99); idle(1);
        check("t4_miss_ascii", 32'(key_ascii), 32'h0);
        check("t4_miss_cnt", 32'(press_cnt), 32'h1);
        send(8'h1C, w);
        send(8'h2A, w);
        check("t4_bp_wait", 32'(w), 32'd1);
        idle(1);
        check("t4_bp_code", 32'(key_code), 32'h2A);
        check("t4_bp_cnt", 32'(press_cnt), 32'h3);

        // protocol error, then counter wrap
        do_reset();
        tx(8'hF0); tx(8'hF0); idle(1);
        check("t5_err", 32'(err), 32'h1);
        tx(8'h1C); idle(1);
        check("t5_after_err_valid", 32'(key_valid), 32'h1);
        check("t5_err_sticky", 32'(err), 32'h1);
        do_reset();
        for (int i = 0; i < 256; i++) begin
            c = 8'(i % 200 + 1);
            tx(c); tx(8'hF0); tx(c);
        end
        idle(1);
        check("t5_wrap", 32'(press_cnt), 32'h0);

        // async reset while in the extended-prefix state
        do_reset();
        tx(8'h1C); idle(1);
        tx(8'hE0);
        #2 clrn = 1'b0;
        #1;
        check("t6_rst_cnt", 32'(press_cnt), 32'h0);
        check("t6_rst_down", 32'(key_down), 32'h0);
        check("t6_rst_code", 32'(key_code), 32'h0);
        check("t6_rst_ascii", 32'(key_ascii), 32'h0);
        check("t6_rst_key", 32'(lut_key), 32'h0);
        clrn = 1'b1;
        @(posedge clk); #1;
        tx(8'h75);
        check("t6_lut_key", 32'(lut_key), 32'h075);
        idle(1);
        check("t6_ext", 32'(key_ext), 32'h0);

        // randomized stream
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            sc_valid = ($urandom_range(0, 3) != 0);
            sc_data  = pool[$urandom_range(0, 5)];
            @(posedge clk); #1;
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
